// File: rtl/wb_lsu_pkg.sv
// wb_lsu_pkg
// Shared definitions for the Wishbone load/store master:
//   - size_e   : request size encodings (byte, half, word, reserved)
//   - state_e  : master FSM state encoding
//   - sel_mask : little-endian byte-lane select for a size/offset pair
//   - is_illegal : misaligned or reserved-size request detection
package wb_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte lanes touched by an access of the given size at byte offset addr_lo.
    // Illegal combinations never reach the bus, so their mask is don't-care.
    function automatic logic [3:0] sel_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: sel_mask = 4'b0001 << addr_lo;
            SZ_HALF: sel_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: sel_mask = 4'b1111;
            default: sel_mask = 4'b0000;
        endcase
    endfunction

    // Requests that are answered with an error without starting a bus cycle.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_illegal = 1'b0;
            SZ_HALF: is_illegal = addr_lo[0];
            SZ_WORD: is_illegal = (addr_lo != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_lsu_lane.sv
// wb_lsu_lane
// Combinational byte-lane steering for the load/store master.
//   size      in  2   access size (wb_lsu_pkg::size_e encoding)
//   addr_lo   in  2   byte offset within the 32-bit word
//   is_signed in  1   sign-extend sub-word loads
//   wdata     in  32  right-aligned store data
//   rdata     in  32  raw bus read data
//   sel       out 4   byte-lane select
//   wdata_rep out 32  store data replicated onto every candidate lane
//   rdata_ext out 32  load data shifted down and zero/sign-extended
module wb_lsu_lane
    import wb_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    // Only the low halfword of the shifted read data is ever used; word
    // loads take the raw bus data directly.
    logic [15:0] shifted;

    always_comb begin
        sel       = sel_mask(size, addr_lo);
        shifted   = 16'(rdata >> {addr_lo, 3'b000});
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SZ_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// wb_lsu_master
// Wishbone classic master turning one CPU load/store request into one bus
// cycle, with lane steering, load extension, and error/misalign/timeout report.
//   clk, rst (sync, active-high)
//   req_valid/req_ready/req_we/req_addr/req_size/req_signed/req_wdata : request
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion pulse and result
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_sel_o/wb_dat_o : bus master outputs
//   wb_dat_i/wb_ack_i/wb_err_i : bus slave response
// Parameters: addr_width (address width), timeout_cycles (0 = no timeout).
module wb_lsu_master
    import wb_lsu_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [addr_width-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [addr_width-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    localparam int CNT_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(timeout_cycles - 1);

    state_e           state;
    logic [1:0]       size_q;
    logic [1:0]       addr_lo_q;
    logic             signed_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    logic [1:0]  lane_size;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign req_ready = (state == IDLE);
    assign tmo_hit   = (timeout_cycles != 0) && (tmo_cnt == TMO_LAST);

    // One lane steerer serves both phases: in IDLE it sees the live request so
    // sel/data can be registered at acceptance; in BUS it sees the latched
    // size/offset so read data can be extracted at the ack edge.
    always_comb begin
        lane_size    = size_q;
        lane_addr_lo = addr_lo_q;
        if (state == IDLE) begin
            lane_size    = req_size;
            lane_addr_lo = req_addr[1:0];
        end
    end

    wb_lsu_lane u_lane (
        .size      (lane_size),
        .addr_lo   (lane_addr_lo),
        .is_signed (signed_q),
        .wdata     (req_wdata),
        .rdata     (wb_dat_i),
        .sel       (lane_sel),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // All bus and response outputs are registered here; reset mid-cycle drops
    // the access silently and the core is expected to reissue it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= 2'b00;
            addr_lo_q <= 2'b00;
            signed_q  <= 1'b0;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= 4'b0000;
            wb_dat_o  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q    <= req_size;
                        addr_lo_q <= req_addr[1:0];
                        signed_q  <= req_signed;
                        if (is_illegal(req_size, req_addr[1:0])) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state    <= BUS;
                            tmo_cnt  <= '0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= req_we;
                            wb_adr_o <= {req_addr[addr_width-1:2], 2'b00};
                            wb_sel_o <= lane_sel;
                            wb_dat_o <= lane_wdata;
                        end
                    end
                end
                BUS: begin
                    if (wb_err_i || wb_ack_i || tmo_hit) begin
                        // err beats a simultaneous ack; a timeout has neither.
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= wb_err_i || !wb_ack_i;
                        rsp_rdata <= (wb_ack_i && !wb_err_i && !wb_we_o) ? lane_rdata : '0;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_adr_o  <= '0;
                        wb_sel_o  <= 4'b0000;
                        wb_dat_o  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master
// Directed bench for wb_lsu_master (timeout_cycles = 4). Expected responses
// are queued when a request is issued and popped by a monitor on rsp_valid;
// bus-side and timing expectations are checked inline at fixed cycles.
module tb_wb_lsu_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    wb_lsu_master #(
        .addr_width     (32),
        .timeout_cycles (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic expectRsp(input logic err, input logic [31:0] rdata);
        exp_t e;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Called mid-cycle in IDLE; the request is taken at the next edge (edge 0)
    // and the task returns just after that edge, in cycle 1.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] wdata, input string tag);
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checkOutput("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_wdata  = '0;
        wb_dat_i   = '0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;

        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rst_we", 32'(wb_we_o), 32'd0);
        checkOutput("rst_sel", 32'(wb_sel_o), 32'd0);
        checkOutput("rst_adr", wb_adr_o, 32'd0);
        checkOutput("rst_dat", wb_dat_o, 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        nextCycle();

        // Word store 0xDEADBEEF to 0x100, ack in cycle 2
        $display("[TB] word store");
        expectRsp(1'b0, 32'h0);
        applyStimulus(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, "stw");
        nextCycle();
        checkOutput("stw_cyc", 32'(wb_cyc_o), 32'd1);
        checkOutput("stw_stb", 32'(wb_stb_o), 32'd1);
        checkOutput("stw_we", 32'(wb_we_o), 32'd1);
        checkOutput("stw_sel", 32'(wb_sel_o), 32'hF);
        checkOutput("stw_adr", wb_adr_o, 32'h100);
        checkOutput("stw_dat", wb_dat_o, 32'hDEADBEEF);
        checkOutput("stw_busy", 32'(req_ready), 32'd0);
        nextCycle();
        wb_ack_i = 1'b1;
        checkOutput("stw_c2_valid", 32'(rsp_valid), 32'd0);
        nextCycle();
        wb_ack_i = 1'b0;
        checkOutput("stw_c3_valid", 32'(rsp_valid), 32'd1);
        checkOutput("stw_c3_cyc", 32'(wb_cyc_o), 32'd0);
        nextCycle();
        checkOutput("stw_c4_valid", 32'(rsp_valid), 32'd0);
        checkOutput("stw_c4_ready", 32'(req_ready), 32'd1);

        // Signed byte load at 0x203, ack in cycle 1
        $display("[TB] signed byte load");
        expectRsp(1'b0, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h203, 2'd0, 1'b1, 32'h0, "lbs");
        nextCycle();
        checkOutput("lbs_sel", 32'(wb_sel_o), 32'h8);
        checkOutput("lbs_adr", wb_adr_o, 32'h200);
        checkOutput("lbs_we", 32'(wb_we_o), 32'd0);
        wb_dat_i = 32'h80FF0000;
        wb_ack_i = 1'b1;
        nextCycle();
        wb_ack_i = 1'b0;
        checkOutput("lbs_c2_valid", 32'(rsp_valid), 32'd1);
        nextCycle();

        // Unsigned byte load at 0x203
        $display("[TB] unsigned byte load");
        expectRsp(1'b0, 32'h00000080);
        applyStimulus(1'b0, 32'h203, 2'd0, 1'b0, 32'h0, "lbu");
        nextCycle();
        wb_ack_i = 1'b1;
        nextCycle();
        wb_ack_i = 1'b0;
        checkOutput("lbu_c2_valid", 32'(rsp_valid), 32'd1);
        nextCycle();

        // Signed half load at 0x102 (upper lanes)
        $display("[TB] signed half load");
        expectRsp(1'b0, 32'hFFFF8001);
        applyStimulus(1'b0, 32'h102, 2'd1, 1'b1, 32'h0, "lhs");
        nextCycle();
        checkOutput("lhs_sel", 32'(wb_sel_o), 32'hC);
        wb_dat_i = 32'h80011234;
        wb_ack_i = 1'b1;
        nextCycle();
        wb_ack_i = 1'b0;
        nextCycle();

        // Byte store 0xA5 at 0x001: replicated data, rdata 0 despite bus data
        $display("[TB] byte store");
        expectRsp(1'b0, 32'h0);
        applyStimulus(1'b1, 32'h001, 2'd0, 1'b0, 32'h123456A5, "stb");
        nextCycle();
        checkOutput("stb_sel", 32'(wb_sel_o), 32'h2);
        checkOutput("stb_dat", wb_dat_o, 32'hA5A5A5A5);
        checkOutput("stb_adr", wb_adr_o, 32'h0);
        wb_dat_i = 32'hFFFFFFFF;
        wb_ack_i = 1'b1;
        nextCycle();
        wb_ack_i = 1'b0;
        nextCycle();

        // Misaligned half load at 0x101: error in cycle 1, no bus cycle
        $display("[TB] misaligned half");
        expectRsp(1'b1, 32'h0);
        applyStimulus(1'b0, 32'h101, 2'd1, 1'b0, 32'h0, "mis");
        nextCycle();
        checkOutput("mis_c1_valid", 32'(rsp_valid), 32'd1);
        checkOutput("mis_c1_cyc", 32'(wb_cyc_o), 32'd0);
        nextCycle();
        checkOutput("mis_c2_ready", 32'(req_ready), 32'd1);

        // Reserved size is rejected the same way
        expectRsp(1'b1, 32'h0);
        applyStimulus(1'b0, 32'h000, 2'd3, 1'b0, 32'h0, "rsv");
        nextCycle();
        checkOutput("rsv_c1_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsv_c1_stb", 32'(wb_stb_o), 32'd0);
        nextCycle();

        // Slave never acks: stb cycles 1-4, error cycle 5, ready cycle 6
        $display("[TB] timeout");
        expectRsp(1'b1, 32'h0);
        applyStimulus(1'b0, 32'h040, 2'd2, 1'b0, 32'h0, "tmo");
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput($sformatf("tmo_c%0d_stb", k), 32'(wb_stb_o), 32'd1);
            checkOutput($sformatf("tmo_c%0d_valid", k), 32'(rsp_valid), 32'd0);
        end
        nextCycle();
        checkOutput("tmo_c5_valid", 32'(rsp_valid), 32'd1);
        checkOutput("tmo_c5_stb", 32'(wb_stb_o), 32'd0);
        nextCycle();
        checkOutput("tmo_c6_ready", 32'(req_ready), 32'd1);

        // ack and err together in cycle 2: err wins
        $display("[TB] ack+err");
        expectRsp(1'b1, 32'h0);
        applyStimulus(1'b0, 32'h080, 2'd2, 1'b0, 32'h0, "ae");
        nextCycle();
        nextCycle();
        wb_dat_i = 32'hCAFEF00D;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        nextCycle();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        checkOutput("ae_c3_valid", 32'(rsp_valid), 32'd1);
        nextCycle();

        // Stray ack while idle is ignored
        wb_ack_i = 1'b1;
        nextCycle();
        checkOutput("stray_valid1", 32'(rsp_valid), 32'd0);
        nextCycle();
        wb_ack_i = 1'b0;
        checkOutput("stray_valid2", 32'(rsp_valid), 32'd0);
        checkOutput("stray_ready", 32'(req_ready), 32'd1);

        // rst in cycle 2 of a stalled access: bus drops, no response
        $display("[TB] reset mid-bus");
        applyStimulus(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, "rmb");
        nextCycle();
        checkOutput("rmb_c1_cyc", 32'(wb_cyc_o), 32'd1);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        checkOutput("rmb_c3_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rmb_c3_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rmb_c3_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        nextCycle();
        checkOutput("rmb_c4_valid", 32'(rsp_valid), 32'd0);

        // New request accepted after reset release
        expectRsp(1'b0, 32'h12345678);
        applyStimulus(1'b0, 32'h304, 2'd2, 1'b0, 32'h0, "post");
        nextCycle();
        checkOutput("post_adr", wb_adr_o, 32'h304);
        wb_dat_i = 32'h12345678;
        wb_ack_i = 1'b1;
        nextCycle();
        wb_ack_i = 1'b0;
        checkOutput("post_c2_valid", 32'(rsp_valid), 32'd1);
        nextCycle();
        nextCycle();

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
